decode_stage: RTL
=================

Name: decode_stage

Overview:
- Parametrised successor to the combinational RV32I decoder.
- Registered decode stage between fetch and execute. Accepts one instruction per cycle over a valid/ready handshake.
- Holds the architectural register bank internally and resolves operands op1/op2/op3 and rd.
- Tracks outstanding writes in a scoreboard and stalls on read-after-write hazards until execute writes back.

Parameters:
XLEN, 32, datapath width; immediates sign-extended to XLEN; legal values 32 or 64.
NREGS, 32, number of architectural registers; legal values 32 or 16 (RV32E); x0 always reads 0.
MAX_PEND, 1, maximum outstanding writes per register (scoreboard counter width clog2(MAX_PEND+1)).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage accepts this cycle
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
out_instr  out  32  instruction passthrough
out_pc  out  XLEN  pc passthrough
out_op1  out  XLEN  operand 1
out_op2  out  XLEN  operand 2
out_op3  out  XLEN  operand 3 (store data / branch offset / link pc)
out_rd  out  5  destination register; 0 if none
out_illegal  out  1  unknown opcode or register index >= NREGS
wb_en  in  1  writeback strobe from execute
wb_rd  in  5  writeback register
wb_data  in  XLEN  writeback value

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0, out_illegal=0, out_rd=0; out_op1/op2/op3/out_instr/out_pc=0.
  - All registers and scoreboard counters cleared; in_ready=0 while rst=0.
  - Reset mid-handshake drops the held bundle; no writeback is lost-tracked.
- Single output register. in_ready = !out_valid || out_ready, AND no hazard.
  - Transfer on in_valid && in_ready.
  - Bundle appears on out_* the next cycle (latency 1).
  - Bundle is held stable while out_valid && !out_ready.
- Operand rules by class:
  - R: op1=R[rs1], op2=R[rs2], op3=0, rd=rd.
  - I / loads / SLTI / SLTIU: op1=R[rs1], op2=imm, op3=0, rd=rd.
  - S: op1=R[rs1], op2=imm, op3=R[rs2], rd=0.
  - B: op1=R[rs1], op2=R[rs2], op3=imm, rd=0.
  - LUI: op1=imm, op2=0, op3=0, rd=rd.
  - AUIPC: op1=pc, op2=imm, op3=0, rd=rd.
  - JAL: op1=pc, op2=imm, op3=pc+4, rd=rd.
  - JALR: op1=R[rs1], op2=imm, op3=pc+4, rd=rd.
- Immediates are built per RISC-V format and sign-extended to XLEN. Shift-immediates use instr[24:20] when XLEN=32 and instr[25:20] when XLEN=64.
- Illegal instructions:
  - out_illegal=1, rd=0, operands 0.
  - Still transferred, never stalled, no scoreboard effect.
- Scoreboard:
  - Accepting an instruction with rd!=0 increments pend[rd].
  - wb_en with wb_rd!=0 writes R[wb_rd]=wb_data and decrements pend[wb_rd].
  - Same-cycle increment and decrement on one register leaves it unchanged.
  - pend[r] never underflows: a spurious wb_en with pend=0 writes data only.
- Hazard (combinational):
  - Asserted if any register the instruction reads has pend!=0, or rd has pend==MAX_PEND.
  - x0 never hazards.
- Writes to x0 are ignored. Register index >= NREGS in rs1/rs2/rd marks the instruction illegal.
- Read during a same-cycle writeback to the same register returns the old value. The hazard stall therefore holds until the cycle after wb_en.

Optional Feature:
- Macro DECODE_WB_BYPASS_EN.
- Defined: a read of register r in the same cycle as wb_en && wb_rd==r returns wb_data. The hazard for r is suppressed that cycle if pend[r]==1, so a dependent instruction is accepted in the writeback cycle.
- Undefined: behaviour as above, with one extra stall cycle.

Test Plan:
- R[1]=5, R[2]=7 preloaded via wb; ADD x5,x1,x2 -> out_op1=5, out_op2=7, out_rd=5, out_valid one cycle after accept.
- SW x2,0x678(x1) -> op1=5, op2=0x678, op3=7, rd=0. BEQ imm=-4 -> op3=0xFFFFFFFC (XLEN=32) or 0xFFFFFFFFFFFFFFFC (XLEN=64).
- ADDI x5,x1,1 followed by ADD x6,x5,x2 -> second held (in_ready=0) until wb_en rd=5 data=6.
  - Then op1=6, accepted one cycle later without bypass, same cycle with DECODE_WB_BYPASS_EN.
- out_ready=0 for 3 cycles with a bundle held -> out_* unchanged, in_ready=0; release -> next instruction accepted.
- NREGS=16, ADD x17,x1,x2 -> out_illegal=1, rd=0. Opcode 0x7F -> out_illegal=1.
- Assert rst=0 while out_valid=1 and pend[5]=1 -> out_valid=0 immediately, pend cleared; after release, ADD x6,x5,x0 issues without stall, op1=0.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I decode stage between fetch and execute.
//
// Accepts one instruction per cycle over a valid/ready handshake. It owns the
// architectural register bank, resolves operands op1/op2/op3 and rd, and keeps a
// per-register count of outstanding writes. An instruction whose source is still
// pending, or whose destination is already at the pending limit, is stalled until
// execute writes the value back.
//
// Parameters:
//   XLEN     - datapath width (32 or 64); immediates sign-extend to XLEN
//   NREGS    - architectural registers (32, or 16 for RV32E); x0 reads 0
//   MAX_PEND - outstanding writes allowed per register
//
// Ports:
//   clk, rst                    clock (rising edge), async active-low reset
//   in_valid/in_ready           fetch handshake
//   in_instr, in_pc             instruction word and its address
//   out_valid/out_ready         execute handshake
//   out_instr, out_pc           passthrough
//   out_op1/op2/op3             resolved operands (op3: store data/branch offset/link pc)
//   out_rd                      destination register, 0 if none
//   out_illegal                 unknown opcode or register index >= NREGS
//   wb_en, wb_rd, wb_data       writeback from execute
//
// Build option:
//   DECODE_WB_BYPASS_EN - forward same-cycle writeback data to operand reads and
//                         release the hazard in the writeback cycle.

`timescale 1ns / 1ps

module decode_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned MAX_PEND = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [XLEN-1:0] out_op3,
  output logic [4:0]      out_rd,
  output logic            out_illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  localparam int unsigned RW = $clog2(NREGS);
  localparam int unsigned PW = $clog2(MAX_PEND + 1);
  localparam logic [PW-1:0] PendMax = PW'(MAX_PEND);

  typedef enum logic [3:0] {
    ClsIllegal, ClsR, ClsI, ClsS, ClsB, ClsLui, ClsAuipc, ClsJal, ClsJalr
  } cls_e;

  // State
  logic [XLEN-1:0] regs_q [NREGS];
  logic [PW-1:0]   pend_q [NREGS];
  logic [PW-1:0]   pend_d [NREGS];

  logic            out_valid_q;
  logic [31:0]     out_instr_q;
  logic [XLEN-1:0] out_pc_q, out_op1_q, out_op2_q, out_op3_q;
  logic [4:0]      out_rd_q;
  logic            out_illegal_q;

  // Field extraction
  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  logic       is_shift;

  assign opcode   = in_instr[6:0];
  assign rd       = in_instr[11:7];
  assign rs1      = in_instr[19:15];
  assign rs2      = in_instr[24:20];
  // SLLI/SRLI/SRAI take a zero-extended shamt rather than the I immediate.
  assign is_shift = (opcode == 7'b0010011) && (in_instr[13:12] == 2'b01);

  // Class decode
  cls_e cls;
  logic uses_rs1, uses_rs2, writes_rd;

  always_comb begin
    cls       = ClsIllegal;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      7'b0110011: begin cls = ClsR; uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
      7'b0010011,
      7'b0000011: begin cls = ClsI; uses_rs1 = 1'b1; writes_rd = 1'b1; end
      7'b0100011: begin cls = ClsS; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b1100011: begin cls = ClsB; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b0110111: begin cls = ClsLui; writes_rd = 1'b1; end
      7'b0010111: begin cls = ClsAuipc; writes_rd = 1'b1; end
      7'b1101111: begin cls = ClsJal; writes_rd = 1'b1; end
      7'b1100111: begin cls = ClsJalr; uses_rs1 = 1'b1; writes_rd = 1'b1; end
      default: ;
    endcase
  end

  // Only fields the class actually uses are range-checked; S/B reuse bits 11:7
  // for immediate data.
  logic bad_idx, illegal;
  assign bad_idx = (uses_rs1 && (32'(rs1) >= NREGS)) ||
                   (uses_rs2 && (32'(rs2) >= NREGS)) ||
                   (writes_rd && (32'(rd) >= NREGS));
  assign illegal = (cls == ClsIllegal) || bad_idx;

  // Immediates
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt, pc_plus4;

  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                in_instr[30:21], 1'b0}));
  assign shamt = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
  assign pc_plus4 = in_pc + XLEN'(4);

  // Register reads and scoreboard lookups
  logic            wb_ok, wb_hit_rs1, wb_hit_rs2;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [PW-1:0]   pend_rs1, pend_rs2, pend_rd;

  assign wb_ok      = wb_en && (wb_rd != '0) && (32'(wb_rd) < NREGS);
  assign wb_hit_rs1 = wb_ok && (wb_rd == rs1);
  assign wb_hit_rs2 = wb_ok && (wb_rd == rs2);
  assign pend_rs1   = pend_q[rs1[RW-1:0]];
  assign pend_rs2   = pend_q[rs2[RW-1:0]];
  assign pend_rd    = pend_q[rd[RW-1:0]];

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != '0) rs1_val = regs_q[rs1[RW-1:0]];
    if (rs2 != '0) rs2_val = regs_q[rs2[RW-1:0]];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_hit_rs1) rs1_val = wb_data;
    if (wb_hit_rs2) rs2_val = wb_data;
`endif
  end

  // Hazard detection
  logic haz_rs1, haz_rs2, haz_rd, hazard;

`ifdef DECODE_WB_BYPASS_EN
  // The last outstanding write retiring this cycle is forwarded, so no stall.
  assign haz_rs1 = uses_rs1 && (rs1 != '0) && (pend_rs1 != '0) &&
                   !(wb_hit_rs1 && (pend_rs1 == PW'(1)));
  assign haz_rs2 = uses_rs2 && (rs2 != '0) && (pend_rs2 != '0) &&
                   !(wb_hit_rs2 && (pend_rs2 == PW'(1)));
`else
  assign haz_rs1 = uses_rs1 && (rs1 != '0) && (pend_rs1 != '0);
  assign haz_rs2 = uses_rs2 && (rs2 != '0) && (pend_rs2 != '0);
`endif
  assign haz_rd  = writes_rd && (rd != '0) && (pend_rd == PendMax);
  assign hazard  = !illegal && (haz_rs1 || haz_rs2 || haz_rd);

  logic accept;
  assign in_ready = rst && (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Operand selection
  logic [XLEN-1:0] op1, op2, op3;
  logic [4:0]      rd_eff;

  always_comb begin
    op1    = '0;
    op2    = '0;
    op3    = '0;
    rd_eff = '0;
    case (cls)
      ClsR:     begin op1 = rs1_val; op2 = rs2_val; rd_eff = rd; end
      ClsI:     begin op1 = rs1_val; op2 = is_shift ? shamt : imm_i; rd_eff = rd; end
      ClsS:     begin op1 = rs1_val; op2 = imm_s; op3 = rs2_val; end
      ClsB:     begin op1 = rs1_val; op2 = rs2_val; op3 = imm_b; end
      ClsLui:   begin op1 = imm_u; rd_eff = rd; end
      ClsAuipc: begin op1 = in_pc; op2 = imm_u; rd_eff = rd; end
      ClsJal:   begin op1 = in_pc; op2 = imm_j; op3 = pc_plus4; rd_eff = rd; end
      ClsJalr:  begin op1 = rs1_val; op2 = imm_i; op3 = pc_plus4; rd_eff = rd; end
      default: ;
    endcase
    if (illegal) begin
      op1    = '0;
      op2    = '0;
      op3    = '0;
      rd_eff = '0;
    end
  end

  // Output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
      out_op1_q     <= '0;
      out_op2_q     <= '0;
      out_op3_q     <= '0;
      out_rd_q      <= '0;
      out_illegal_q <= 1'b0;
    end else if (accept) begin
      out_valid_q   <= 1'b1;
      out_instr_q   <= in_instr;
      out_pc_q      <= in_pc;
      out_op1_q     <= op1;
      out_op2_q     <= op2;
      out_op3_q     <= op3;
      out_rd_q      <= rd_eff;
      out_illegal_q <= illegal;
    end else if (out_ready) begin
      out_valid_q   <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign out_op1     = out_op1_q;
  assign out_op2     = out_op2_q;
  assign out_op3     = out_op3_q;
  assign out_rd      = out_rd_q;
  assign out_illegal = out_illegal_q;

  // Scoreboard next state; a writeback with nothing pending leaves the count at 0.
  logic inc_en;
  assign inc_en = accept && !illegal && writes_rd && (rd != '0);

  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      pend_d[r] = pend_q[r];
      if ((inc_en && (rd[RW-1:0] == RW'(r))) &&
          !(wb_ok && (wb_rd[RW-1:0] == RW'(r)) && (pend_q[r] != '0))) begin
        pend_d[r] = pend_q[r] + PW'(1);
      end else if (!(inc_en && (rd[RW-1:0] == RW'(r))) &&
                   (wb_ok && (wb_rd[RW-1:0] == RW'(r)) && (pend_q[r] != '0))) begin
        pend_d[r] = pend_q[r] - PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        pend_q[r] <= '0;
        regs_q[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        pend_q[r] <= pend_d[r];
      end
      if (wb_ok) regs_q[wb_rd[RW-1:0]] <= wb_data;
    end
  end

endmodule
